edge_row_writer: RTL and testbench
==================================

Name: edge_row_writer

Overview:
- Downstream stage of the edge-detection coprocessor.
- Accepts one 64-bit binary edge row per strobe from the coprocessor (line strobe plus row word) and buffers rows in a small FIFO.
- Splits each row into two 32-bit words and writes them into the 32-bit-wide result RAM read by the VGA path, starting at a base address.
- Signals completion after a fixed row count per frame.

Parameters:
- FIFO_DEPTH, 4: rows buffered; power of two, 2..16.
- ADDR_W, 12: result RAM address width.
- ROWS_PER_FRAME, 64: rows written before frame_done.

Ports:
- clk_50M  in  1  system clock.
- reset  in  1  synchronous, active-low.
- base_addr  in  ADDR_W  result image base address; sampled on accepted frame_start.
- frame_start  in  1  single-cycle pulse; arms a new frame.
- line_valid  in  1  single-cycle row strobe from the coprocessor.
- line_data  in  64  edge row; bit 0 is the leftmost pixel.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  32  RAM write data.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last word of the frame is written.
- overflow  out  1  sticky; a row was dropped because the FIFO was full.
- lines_written  out  7  rows fully written in the current frame.

Behaviour:
- Reset (already decided): reset reset, synchronous, active-low; clock clk_50M.
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset mid-frame: next edge forces IDLE, discards FIFO contents, drops wr_en the same cycle; no partial-row completion.
- States:
  - IDLE: frame_start latches base_addr, clears lines_written and overflow, goes to ARMED. line_valid is ignored (not pushed) in IDLE.
  - ARMED: FIFO non-empty goes to WR_LO.
  - WR_LO: wr_en=1, wr_addr=base+2*lines_written, wr_data=head[31:0]; goes to WR_HI.
  - WR_HI: wr_en=1, wr_addr=base+2*lines_written+1, wr_data=head[63:32]; pops the FIFO and increments lines_written. Goes to DONE if the new count equals ROWS_PER_FRAME, else to WR_LO if more rows remain, else to ARMED.
  - DONE: frame_done=1 for one cycle, then IDLE. Leftover FIFO contents are flushed on entry to IDLE.
- wr_en, wr_addr and wr_data are Moore outputs, decoded from state, head and counters.
- Latency: a row pushed on edge N while ARMED and the FIFO is empty gives its lower word with wr_en high in the cycle after edge N+1. The upper word follows in the next cycle.
- Throughput: 2 cycles per row, back-to-back.
- Address arithmetic is modulo 2^ADDR_W; wrap past 4095 is silent.
- FIFO:
  - Push when line_valid is high and state is not IDLE.
  - Full with no pop in the same cycle: row dropped, overflow set.
  - Full with a simultaneous pop in WR_HI: push accepted, count unchanged.
  - Empty: no pop is possible because WR_LO is never entered.
- frame_start while busy is ignored; base address and counters are unchanged.
- frame_start and line_valid in the same cycle in IDLE: frame armed, row not pushed.
- lines_written saturates at ROWS_PER_FRAME.

Optional Feature:
- EDGE_INVERT_EN defined: wr_data is the bitwise inverse of the selected half-row, so edges are stored as 0 on a white background.
- Undefined: data is written unmodified.
- Flags, counters and timing are identical in both builds.

Decomposition:
- Shared package (edge_pkg):
  - State enum: IDLE, ARMED, WR_LO, WR_HI, DONE.
  - ROW_W=64, WORD_W=32, default ADDR_W, default ROWS_PER_FRAME.
- Sub-module edge_row_fifo: synchronous FIFO, parameter FIFO_DEPTH, ports push/pop/din/dout/full/empty; first-word-fall-through head.

Test Plan:
- Basic: reset low 2 cycles, then frame_start with base_addr=0x100, then line_valid with line_data=0x0123456789ABCDEF -> writes (0x100,0x89ABCDEF) then (0x101,0x01234567); lines_written=1.
- Burst/overflow (FIFO_DEPTH=4): 6 consecutive line_valid while WR_LO/WR_HI is busy on the first row.
  - Overflow sets on the 6th strobe.
  - 5 rows written at base+0..9.
  - Overflow clears on the next frame_start.
- Frame end: ROWS_PER_FRAME=64 rows at base_addr=0xFC0.
  - Last write at 0x03F after wrap.
  - frame_done high exactly one cycle after that write; busy=0 next cycle.
- Mid-frame reset: reset low during WR_HI of row 3 -> wr_en=0 next cycle, lines_written=0, FIFO empty; a later frame_start restarts at the new base.
- Ignored inputs:
  - frame_start while busy leaves base_addr latched unchanged.
  - line_valid in IDLE produces no write.
- EDGE_INVERT_EN build: row 0x0 -> both words 0xFFFFFFFF; frame_done timing identical to the default build.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection result writer.
//   edge_state_t : writer FSM states
//   ROW_W/WORD_W : row and RAM word widths
//   DEF_*        : default address width and rows per frame
//   row_half     : selects the lower or upper word of a row
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } edge_state_t;

  localparam int ROW_W              = 64;
  localparam int WORD_W             = 32;
  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_ROWS_PER_FRAME = 64;

  // Bit 0 of a row is the leftmost pixel, so the lower word is written first.
  function automatic logic [WORD_W-1:0] row_half(input logic [ROW_W-1:0] row,
                                                 input logic hi);
    return hi ? row[ROW_W-1:WORD_W] : row[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/edge_row_fifo.sv
// Small synchronous row FIFO with first-word-fall-through head.
// Ports:
//   clk_50M, reset (sync, active-low)
//   flush  : discard all contents on the next edge
//   push   : write din; accepted when not full, or when full with a pop
//   pop    : drop head; ignored when empty
//   din    : row in
//   dout   : current head row (valid while !empty)
//   full, empty, level : occupancy
module edge_row_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 64
) (
  input  logic                            clk_50M,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                din,
  output logic [WIDTH-1:0]                dout,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic do_push;
  logic do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_L);
  assign level   = count_reg;
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_50M) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_50M) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/edge_row_writer.sv
// Writes 64-bit edge rows from the coprocessor into the 32-bit result RAM.
// Each row becomes two words at base + 2*row (lower half) and +1 (upper).
// Optional build macro EDGE_INVERT_EN: store inverted data (edges as 0).
// Ports:
//   clk_50M, reset (sync, active-low)
//   base_addr     : frame base, latched on an accepted frame_start
//   frame_start   : arms a frame (ignored unless idle)
//   line_valid    : row strobe, line_data is the row
//   wr_en/wr_addr/wr_data : RAM write port
//   busy, frame_done, overflow (sticky), lines_written
module edge_row_writer
  import edge_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              frame_start,
  input  logic              line_valid,
  input  logic [ROW_W-1:0]  line_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [6:0]        lines_written
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [6:0] ROWS_LAST = 7'(ROWS_PER_FRAME);

  edge_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [6:0]        lines_reg;
  logic              overflow_reg;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [ROW_W-1:0]  fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic [6:0]        lines_inc;
  logic              hi_sel;
  logic [WORD_W-1:0] half_word;

  assign fifo_push  = line_valid && (state_reg != IDLE);
  assign fifo_pop   = (state_reg == WR_HI);
  // Leftover rows are discarded on the way back to IDLE.
  assign fifo_flush = (state_reg == DONE);
  assign lines_inc  = lines_reg + 7'd1;
  assign hi_sel     = (state_reg == WR_HI);

  edge_row_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (ROW_W)
  ) u_fifo (
    .clk_50M(clk_50M),
    .reset  (reset),
    .flush  (fifo_flush),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (line_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      lines_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && frame_start) begin
        base_reg     <= base_addr;
        lines_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (state_reg == WR_HI && lines_reg != ROWS_LAST) begin
          lines_reg <= lines_inc;
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (frame_start) state_next = ARMED;
      ARMED: if (!fifo_empty) state_next = WR_LO;
      WR_LO: state_next = WR_HI;
      WR_HI: begin
        // A push this cycle always lands (the pop frees a slot), so it
        // counts as a remaining row alongside anything behind the head.
        if (lines_inc == ROWS_LAST)
          state_next = DONE;
        else if (fifo_level > LVL_W'(1) || fifo_push)
          state_next = WR_LO;
        else
          state_next = ARMED;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef EDGE_INVERT_EN
  assign half_word = ~row_half(fifo_dout, hi_sel);
`else
  assign half_word = row_half(fifo_dout, hi_sel);
`endif

  // Address and data are held at zero outside the write states.
  assign wr_en         = (state_reg == WR_LO) || (state_reg == WR_HI);
  assign wr_addr       = wr_en ? base_reg + ADDR_W'({lines_reg, hi_sel}) : '0;
  assign wr_data       = wr_en ? half_word : '0;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = (state_reg == DONE);
  assign overflow      = overflow_reg;
  assign lines_written = lines_reg;

endmodule

// File: tb/tb_edge_row_writer.sv
module tb_edge_row_writer;

  logic        clk_50M;
  logic        reset;
  logic [11:0] base_addr;
  logic        frame_start;
  logic        line_valid;
  logic [63:0] line_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic [6:0]  lines_written;

  int checks_count = 0;
  int errors_count = 0;
  int wr_seen      = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  edge_row_writer dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .base_addr    (base_addr),
    .frame_start  (frame_start),
    .line_valid   (line_valid),
    .line_data    (line_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .lines_written(lines_written)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_count++;
    if (obs !== exp) begin
      errors_count++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [63:0] row, input bit hi);
    logic [31:0] w;
    w = hi ? row[63:32] : row[31:0];
`ifdef EDGE_INVERT_EN
    w = ~w;
`endif
    return w;
  endfunction

  task automatic queue_row(input logic [11:0] base, input int idx, input logic [63:0] row);
    wr_t e;
    e.addr = base + 12'(2 * idx);
    e.data = exp_word(row, 1'b0);
    exp_q.push_back(e);
    e.addr = base + 12'(2 * idx + 1);
    e.data = exp_word(row, 1'b1);
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; holds the strobe for exactly one edge.
  task automatic strobe(input logic [63:0] row);
    line_valid = 1'b1;
    line_data  = row;
    @(posedge clk_50M);
    #1;
    line_valid = 1'b0;
  endtask

  // Returns at the negedge where the given address is written.
  task automatic wait_addr(input logic [11:0] a, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50M);
      if (wr_en && wr_addr == a) begin
        found = 1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk_50M) begin
    if (wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'h0, wr_addr, wr_data}, 64'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        $display("write addr=%03h data=%08h", wr_addr, wr_data);
      end
    end
  end

  initial begin
    logic [63:0] r;
    int          seen_before;

    reset       = 1'b0;
    frame_start = 1'b0;
    line_valid  = 1'b0;
    base_addr   = '0;
    line_data   = '0;

    // Reset state
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lines", lines_written, 0);
    @(posedge clk_50M); #1;
    reset = 1'b1;

    // Basic frame at 0x100 with latency check
    base_addr = 12'h100; frame_start = 1'b1;
    @(posedge clk_50M); #1;
    frame_start = 1'b0; base_addr = 12'h000;
    queue_row(12'h100, 0, 64'h0123456789ABCDEF);
    strobe(64'h0123456789ABCDEF);
    @(negedge clk_50M);
    check("lat_push_cycle_wr_en", wr_en, 0);
    check("busy_armed", busy, 1);
    @(negedge clk_50M);
    check("lat_lo_wr_en", wr_en, 1);
    check("lat_lo_addr", wr_addr, 12'h100);
    @(negedge clk_50M);
    check("lat_hi_wr_en", wr_en, 1);
    check("lat_hi_addr", wr_addr, 12'h101);
    @(negedge clk_50M);
    check("lines_after_row0", lines_written, 1);

    // frame_start while busy must not move the base
    @(posedge clk_50M); #1;
    base_addr = 12'h200; frame_start = 1'b1;
    @(posedge clk_50M); #1;
    frame_start = 1'b0;
    queue_row(12'h100, 1, 64'h0);
    strobe(64'h0);
    for (int k = 2; k <= 4; k++) begin
      r = {$urandom, $urandom};
      queue_row(12'h100, k, r);
      strobe(r);
    end

    // Reset during the upper-word write of row 3
    wait_addr(12'h107, "wait_row3_hi");
    check("lines_before_rst", lines_written, 3);
    reset = 1'b0;
    @(posedge clk_50M); #1;
    exp_q.delete();
    @(negedge clk_50M);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_lines", lines_written, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b1;

    // line_valid in IDLE produces nothing
    @(posedge clk_50M); #1;
    seen_before = wr_seen;
    strobe({$urandom, $urandom});
    repeat (5) @(negedge clk_50M);
    check("idle_line_no_write", wr_seen, seen_before);
    check("idle_busy", busy, 0);

    // Frame at 0xFC0: frame_start with simultaneous strobe (not pushed),
    // then 7 back-to-back strobes. Pops land on the 4th and 6th strobe
    // edges, so the FIFO of 4 is full with no pop on the 7th: dropped.
    @(posedge clk_50M); #1;
    base_addr = 12'hFC0; frame_start = 1'b1;
    line_valid = 1'b1; line_data = 64'hDEADDEADDEADDEAD;
    @(posedge clk_50M); #1;
    frame_start = 1'b0; base_addr = 12'h000;
    for (int k = 0; k < 7; k++) begin
      r = {$urandom, $urandom};
      if (k < 6) queue_row(12'hFC0, k, r);
      line_valid = 1'b1;
      line_data  = r;
      @(posedge clk_50M);
      @(negedge clk_50M);
      check($sformatf("burst_overflow_%0d", k + 1), overflow, (k == 6) ? 1 : 0);
    end
    line_valid = 1'b0;

    for (int k = 6; k < 64; k++) begin
      r = (k == 40) ? 64'h0 : {$urandom, $urandom};
      queue_row(12'hFC0, k, r);
      line_valid = 1'b1;
      line_data  = r;
      @(posedge clk_50M); #1;
      line_valid = 1'b0;
      repeat (2) @(posedge clk_50M);
      #1;
    end

    // Last word wraps to 0x03F; frame_done follows in the next cycle
    wait_addr(12'h03F, "wait_last_write");
    check("last_write_no_done", frame_done, 0);
    check("last_write_lines", lines_written, 63);
    @(negedge clk_50M);
    check("frame_done_pulse", frame_done, 1);
    check("done_busy", busy, 1);
    check("done_wr_en", wr_en, 0);
    check("done_lines", lines_written, 64);
    @(negedge clk_50M);
    check("frame_done_drop", frame_done, 0);
    check("idle_after_done", busy, 0);
    check("overflow_sticky", overflow, 1);
    check("lines_saturated", lines_written, 64);

    // Next frame clears overflow and the row counter
    @(posedge clk_50M); #1;
    base_addr = 12'h040; frame_start = 1'b1;
    @(posedge clk_50M); #1;
    frame_start = 1'b0;
    @(negedge clk_50M);
    check("new_frame_overflow", overflow, 0);
    check("new_frame_lines", lines_written, 0);
    check("new_frame_busy", busy, 1);
    @(posedge clk_50M); #1;
    r = {$urandom, $urandom};
    queue_row(12'h040, 0, r);
    strobe(r);
    wait_addr(12'h041, "wait_new_frame_hi");
    @(negedge clk_50M);
    check("new_frame_lines_1", lines_written, 1);

    repeat (3) @(negedge clk_50M);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
    $finish;
  end

endmodule
